// File: rtl/task3_demux_if.sv
// Bus between a word source and the task3_demux steering block.
// Valid/ready: a word moves on a rising edge where in_valid and in_ready are both high; the source holds din/sel until then.
interface task3_demux_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic [3:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic             commit;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic             out_valid;
    logic [3:0]       wr_mask;
    logic             err;

    modport master (
        output din, sel, in_valid, commit,
        input  in_ready, a, b, d, e, out_valid, wr_mask, err
    );

    modport slave (
        input  din, sel, in_valid, commit,
        output in_ready, a, b, d, e, out_valid, wr_mask, err
    );
endinterface

// File: rtl/task3_demux.sv
// Steers tagged words into four shadow channels (a/b/d/e) and publishes
// all four together on commit, with a one-cycle out_valid pulse.
module task3_demux #(
    parameter int         WIDTH = 4,
    parameter logic [3:0] AUTO  = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    task3_demux_if.slave  bus,
    output logic [1:0]    state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [3:0][WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]       a_q, b_q, d_q, e_q;
    logic                   out_valid_q, err_q;
    logic [3:0]             wr_mask_q;
    logic [1:0]             rr;
    logic                   xfer, is_auto, legal, wr_en;
    logic [1:0]             ch;

    assign xfer    = bus.in_valid & bus.in_ready;
    assign is_auto = (bus.sel == AUTO);
    assign legal   = (bus.sel < 4'd4) | is_auto;
    assign ch      = is_auto ? rr : bus.sel[1:0];
    assign wr_en   = xfer & legal;

    // Only COMMIT stalls the source; the publish happens on the edge leaving it.
    assign bus.in_ready  = (state != COMMIT);
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.d         = d_q;
    assign bus.e         = e_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wr_mask   = wr_mask_q;
    assign bus.err       = err_q;
    assign state_dbg     = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_en) state_nxt = bus.commit ? COMMIT : FILL;
            FILL:    if (bus.commit) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wr_mask_q   <= 4'h0;
            rr          <= 2'd0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state == COMMIT);
            err_q       <= xfer & ~legal;
            if (state == COMMIT) begin
                // Shadows are kept, so unwritten channels republish their old value.
                a_q       <= shadow[0];
                b_q       <= shadow[1];
                d_q       <= shadow[2];
                e_q       <= shadow[3];
                wr_mask_q <= 4'h0;
                rr        <= 2'd0;
            end else if (wr_en) begin
                shadow[ch]    <= bus.din;
                wr_mask_q[ch] <= 1'b1;
                if (is_auto) rr <= rr + 2'd1;
            end
        end
    end
endmodule
